// File: rtl/nibble_add_seq.sv
// nibble_add_seq: wide adder built from one 4-bit slice reused over NIBBLES
// cycles, least significant nibble first, with the carry held in a register.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | one nibble per edge, carry rippled through carry_r
// DONE  | one-cycle done pulse; result already held on sum/ovf
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 ci,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES:0]   sum,
  output logic                 ovf
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [W-1:0]     a_r, b_r, partial, partial_next;
  logic             carry_r;
  logic [IDX_W-1:0] idx;
  logic [IDX_W+1:0] bit_base;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       slice;
  logic             last_nib;

  // Select the current nibble of each operand and run it through the slice.
  assign bit_base = {idx, 2'b00};
  assign a_nib    = a_r[bit_base +: 4];
  assign b_nib    = b_r[bit_base +: 4];
  assign slice    = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_r};
  assign last_nib = (idx == IDX_LAST);

  // Merge this cycle's nibble into the partial so the final edge can load it whole.
  always_comb begin
    partial_next = partial;
    partial_next[bit_base +: 4] = slice[3:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-nibble accumulation and result load at RUN exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      partial <= '0;
      sum     <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= ci;
            idx     <= '0;
            partial <= '0;
          end
        end
        RUN: begin
          partial <= partial_next;
          carry_r <= slice[4];
          idx     <= idx + 1'b1;
          if (last_nib) begin
            sum <= {slice[4], partial_next};
            ovf <= (a_r[W-1] == b_r[W-1]) && (partial_next[W-1] != a_r[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq with NIBBLES=4.
module tb_nibble_add_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
  logic         busy, done, ovf;
  logic [W:0]   sum;

  int checks = 0;
  int errors = 0;

  nibble_add_seq #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .sum(sum), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Issue one op, then check busy for NIB cycles, the done cycle and the hold cycle.
  task automatic run_and_check(input string name, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic civ,
                               input logic [W:0] exp_sum, input logic exp_ovf);
    @(negedge clk);
    a = av; b = bv; ci = civ; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv; ci = ~civ;
    for (int i = 0; i < NIB; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s run_cycle%0d busy=%b done=%b required busy=1 done=0", name, i, busy, done);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== exp_sum || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s done_cycle done=%b busy=%b sum=%h ovf=%b required done=1 busy=0 sum=%h ovf=%b",
               name, done, busy, sum, ovf, exp_sum, exp_ovf);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== exp_sum || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s hold done=%b busy=%b sum=%h ovf=%b required done=0 busy=0 sum=%h ovf=%b",
               name, done, busy, sum, ovf, exp_sum, exp_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset busy=%b done=%b sum=%h ovf=%b required all zero", busy, done, sum, ovf);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL idle busy=%b done=%b sum=%h ovf=%b required all zero", busy, done, sum, ovf);
      end
    end
  endtask

  task automatic test_basic();
    run_and_check("basic", 16'h0003, 16'h0004, 1'b0, 17'h00007, 1'b0);
  endtask

  task automatic test_ripple();
    run_and_check("ripple_ffff", 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0);
    run_and_check("ripple_7777", 16'h7777, 16'h7777, 1'b1, 17'h0EEEF, 1'b1);
  endtask

  task automatic test_overflow();
    run_and_check("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1);
    run_and_check("ovf_neg", 16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1);
  endtask

  task automatic test_start_while_busy();
    int ndone = 0;
    @(negedge clk);
    a = 16'h0002; b = 16'h0005; ci = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (sum !== 17'h00008) begin
          errors++;
          $display("FAIL busy_start sum=%h required 00008", sum);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL busy_start done_count=%0d required 1", ndone);
    end
    run_and_check("after_busy", 16'h1111, 16'h1111, 1'b0, 17'h02222, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    int ndone = 0;
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b sum=%h ovf=%b required all zero", busy, done, sum, ovf);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL mid_reset activity_cycles=%0d required 0", ndone);
    end
    run_and_check("after_reset", 16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    int both = 0;
    int dd = 0;
    logic prev_done = 1'b0;
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; ci = 1'b0; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b1 && done === 1'b1) both++;
      if (prev_done === 1'b1 && done === 1'b1) dd++;
      prev_done = done;
      if (done === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    start = 1'b0;
    checks++;
    if (first < 0 || second - first != NIB + 2) begin
      errors++;
      $display("FAIL b2b first=%0d second=%0d required period %0d", first, second, NIB + 2);
    end
    checks++;
    if (both != 0 || dd != 0) begin
      errors++;
      $display("FAIL b2b busy_and_done=%0d done_twice=%0d required 0 0", both, dd);
    end
    checks++;
    if (sum !== 17'h00002) begin
      errors++;
      $display("FAIL b2b sum=%h required 00002", sum);
    end
    repeat (NIB + 3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_overflow();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
